// File: rtl/jt12_wr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jt12_wr_sched                                                 |
// | Purpose  : Two-port write scheduler for the jt12 bus interface. Queues   |
// |            (bank, reg, value) writes and replays them as spaced address/ |
// |            data strobe pairs, waiting on the busy flag between writes.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module jt12_wr_sched #(
  parameter int DEPTH    = 8,
  parameter int GAP      = 2,
  parameter int BUSY_MIN = 2,
  parameter int TMO      = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen,
  input  logic                     req0,
  input  logic                     bank0,
  input  logic [7:0]               reg0,
  input  logic [7:0]               val0,
  output logic                     ack0,
  input  logic                     req1,
  input  logic                     bank1,
  input  logic [7:0]               reg1,
  input  logic [7:0]               val1,
  output logic                     ack1,
  output logic [1:0]               chip_addr,
  output logic [7:0]               chip_din,
  output logic                     chip_cs_n,
  output logic                     chip_wr_n,
  input  logic [7:0]               chip_dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     idle,
  output logic                     tmo_err,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] C_FULL = LW'(DEPTH);
  localparam logic [7:0]    C_GAP  = 8'(GAP);
  localparam logic [7:0]    C_BMIN = 8'(BUSY_MIN);
  localparam logic [7:0]    C_TMO  = 8'(TMO);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_GAP_A  = 3'd2,
    S_WR_D   = 3'd3,
    S_WAIT_B = 3'd4
  } state_t;

  // Entry layout: {bank, reg[7:0], val[7:0]}
  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [16:0]   hold_q, hold_d, head;
  logic [1:0]    chip_addr_q, chip_addr_d;
  logic [7:0]    chip_din_q, chip_din_d;
  logic          chip_cs_n_q, chip_cs_n_d, chip_wr_n_q, chip_wr_n_d;
  logic          idle_q, idle_d, tmo_err_q, tmo_err_d;
  logic          full, push0, push1, push, pop, tmo_set;
  logic [16:0]   push_data;
  logic          unused_dout;

  assign unused_dout = ^chip_dout[6:0];
  assign head        = mem_q[rd_ptr_q];
  assign cnt_inc     = cnt_q + 8'd1;

  // Requester arbitration and FIFO bookkeeping; a port whose ack is showing
  // still holds its old request, so it is masked for that cycle.
  always_comb begin
    full      = (level_q == C_FULL);
    push0     = req0 && !ack0_q && !full;
    push1     = req1 && !ack1_q && !full && !(req0 && !ack0_q);
    push      = push0 || push1;
    push_data = push0 ? {bank0, reg0, val0} : {bank1, reg1, val1};
    pop       = cen && (state_q == S_IDLE) && (level_q != '0);
    ack0_d    = push0;
    ack1_d    = push1;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  // Bus sequencer: next state and registered strobe values, advancing on cen only.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    chip_addr_d = chip_addr_q;
    chip_din_d  = chip_din_q;
    chip_cs_n_d = chip_cs_n_q;
    chip_wr_n_d = chip_wr_n_q;
    tmo_set     = 1'b0;
    if (cen) begin
      case (state_q)
        S_IDLE: begin
          if (level_q != '0) begin
            hold_d      = head;
            chip_addr_d = {head[16], 1'b0};
            chip_din_d  = head[15:8];
            chip_cs_n_d = 1'b0;
            chip_wr_n_d = 1'b0;
            cnt_d       = 8'd0;
            state_d     = S_WR_A;
          end
        end
        S_WR_A: begin
          chip_cs_n_d = 1'b1;
          chip_wr_n_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = S_GAP_A;
        end
        S_GAP_A: begin
          if (cnt_inc >= C_GAP) begin
            chip_addr_d = {hold_q[16], 1'b1};
            chip_din_d  = hold_q[7:0];
            chip_cs_n_d = 1'b0;
            chip_wr_n_d = 1'b0;
            cnt_d       = 8'd0;
            state_d     = S_WR_D;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_WR_D: begin
          chip_cs_n_d = 1'b1;
          chip_wr_n_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = S_WAIT_B;
        end
        S_WAIT_B: begin
          if (cnt_inc >= C_BMIN && !chip_dout[7]) begin
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else if (cnt_inc >= C_TMO) begin
            tmo_set = 1'b1;
            cnt_d   = 8'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          chip_cs_n_d = 1'b1;
          chip_wr_n_d = 1'b1;
          cnt_d       = 8'd0;
          state_d     = S_IDLE;
        end
      endcase
    end
    idle_d    = (level_d == '0) && (state_d == S_IDLE);
    tmo_err_d = tmo_set || (tmo_err_q && !clr_err);
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  // State registers; reset abandons any write in flight and empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      hold_q      <= '0;
      chip_addr_q <= 2'd0;
      chip_din_q  <= 8'd0;
      chip_cs_n_q <= 1'b1;
      chip_wr_n_q <= 1'b1;
      idle_q      <= 1'b1;
      tmo_err_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      chip_addr_q <= chip_addr_d;
      chip_din_q  <= chip_din_d;
      chip_cs_n_q <= chip_cs_n_d;
      chip_wr_n_q <= chip_wr_n_d;
      idle_q      <= idle_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign chip_addr = chip_addr_q;
  assign chip_din  = chip_din_q;
  assign chip_cs_n = chip_cs_n_q;
  assign chip_wr_n = chip_wr_n_q;
  assign level     = level_q;
  assign idle      = idle_q;
  assign tmo_err   = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_wr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jt12_wr_sched                                              |
// | Purpose  : Directed self-checking bench for jt12_wr_sched.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_jt12_wr_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       req0 = 1'b0, bank0 = 1'b0, req1 = 1'b0, bank1 = 1'b0;
  logic [7:0] reg0 = 8'd0, val0 = 8'd0, reg1 = 8'd0, val1 = 8'd0;
  logic       ack0, ack1;
  logic [1:0] chip_addr;
  logic [7:0] chip_din;
  logic       chip_cs_n, chip_wr_n;
  logic       busy = 1'b0;
  logic [7:0] chip_dout;
  logic [3:0] level;
  logic       idle, tmo_err;
  logic       clr_err = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cen_div = 1;
  int cen_cnt = 0;
  int max_level = 0;

  assign chip_dout = {busy, 7'h15};

  jt12_wr_sched #(.DEPTH(8), .GAP(2), .BUSY_MIN(2), .TMO(255)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .req0(req0), .bank0(bank0), .reg0(reg0), .val0(val0), .ack0(ack0),
    .req1(req1), .bank1(bank1), .reg1(reg1), .val1(val1), .ack1(ack1),
    .chip_addr(chip_addr), .chip_din(chip_din), .chip_cs_n(chip_cs_n),
    .chip_wr_n(chip_wr_n), .chip_dout(chip_dout), .level(level),
    .idle(idle), .tmo_err(tmo_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Cycle counter and clock-enable pattern (always, never, or every 6th clk)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cen_div == 6) cen_cnt <= (cen_cnt == 5) ? 0 : cen_cnt + 1;
    cen <= (cen_div == 1) ? 1'b1 : ((cen_div == 6) ? (cen_cnt == 5) : 1'b0);
  end

  // Strobe recorder: one entry per low pulse of cs_n/wr_n
  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
    int         start;
    int         width;
  } strobe_t;
  strobe_t    ev_q[$];
  logic       prev_low = 1'b0;
  int         cur_start = 0;
  logic [1:0] cur_addr = 2'd0;
  logic [7:0] cur_din = 8'd0;

  always @(negedge clk) begin
    if (!chip_cs_n && !chip_wr_n) begin
      if (!prev_low) begin
        cur_start = cyc;
        cur_addr  = chip_addr;
        cur_din   = chip_din;
      end
      prev_low = 1'b1;
    end else begin
      if (prev_low) ev_q.push_back('{cur_addr, cur_din, cur_start, cyc - cur_start});
      prev_low = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (int'(level) > max_level) max_level = int'(level);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one write, hold it until ack, then release; reports ack latency
  // in clk and the ack level one clk after it was seen.
  task automatic send(input int port, input logic b, input logic [7:0] r, input logic [7:0] v,
                      input int budget, output int lat, output logic ack_after);
    lat = -1;
    if (port == 0) begin req0 = 1'b1; bank0 = b; reg0 = r; val0 = v; end
    else           begin req1 = 1'b1; bank1 = b; reg1 = r; val1 = v; end
    for (int k = 1; k <= budget; k++) begin
      step();
      if ((port == 0 && ack0) || (port == 1 && ack1)) begin
        lat = k;
        break;
      end
    end
    check("ack_seen", (lat > 0), 1);
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
    step();
    ack_after = (port == 0) ? ack0 : ack1;
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      step();
      if (idle) begin
        at = cyc;
        break;
      end
    end
    check("idle_reached", (at >= 0), 1);
  endtask

  typedef struct {
    int         port;
    logic       bank;
    logic [7:0] rg;
    logic [7:0] vl;
    logic [1:0] ea_a;
    logic [7:0] ed_a;
    logic [1:0] ea_d;
    logic [7:0] ed_d;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   b, lat, ic, nack, tcyc;
    logic aa;

    vecs[0] = '{0, 1'b1, 8'h28, 8'hF0, 2'd2, 8'h28, 2'd3, 8'hF0};
    vecs[1] = '{1, 1'b0, 8'hA4, 8'h22, 2'd0, 8'hA4, 2'd1, 8'h22};
    vecs[2] = '{0, 1'b0, 8'h30, 8'h71, 2'd0, 8'h30, 2'd1, 8'h71};
    vecs[3] = '{1, 1'b1, 8'hB4, 8'hC0, 2'd2, 8'hB4, 2'd3, 8'hC0};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_cs_n", chip_cs_n, 1);
    check("rst_wr_n", chip_wr_n, 1);
    check("rst_addr", chip_addr, 0);
    check("rst_din", chip_din, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_level", level, 0);
    check("rst_idle", idle, 1);
    check("rst_tmo", tmo_err, 0);

    // Single writes, cen always high, busy low
    for (int i = 0; i < 4; i++) begin
      b = ev_q.size();
      send(vecs[i].port, vecs[i].bank, vecs[i].rg, vecs[i].vl, 20, lat, aa);
      wait_idle(100, ic);
      check($sformatf("v%0d_ack_lat", i), lat, 1);
      check($sformatf("v%0d_ack_pulse", i), aa, 0);
      check($sformatf("v%0d_nstrobe", i), ev_q.size() - b, 2);
      if (ev_q.size() - b >= 2) begin
        check($sformatf("v%0d_addr_a", i), ev_q[b].addr, vecs[i].ea_a);
        check($sformatf("v%0d_din_a", i), ev_q[b].din, vecs[i].ed_a);
        check($sformatf("v%0d_width_a", i), ev_q[b].width, 1);
        check($sformatf("v%0d_addr_d", i), ev_q[b+1].addr, vecs[i].ea_d);
        check($sformatf("v%0d_din_d", i), ev_q[b+1].din, vecs[i].ed_d);
        check($sformatf("v%0d_width_d", i), ev_q[b+1].width, 1);
        check($sformatf("v%0d_gap", i), ev_q[b+1].start - ev_q[b].start, 3);
        check($sformatf("v%0d_idle_at", i), ic - ev_q[b].start, 6);
      end
    end

    // Arbitration: both ports request in the same clk
    b = ev_q.size();
    req0 = 1'b1; bank0 = 1'b0; reg0 = 8'h40; val0 = 8'h11;
    req1 = 1'b1; bank1 = 1'b1; reg1 = 8'h50; val1 = 8'h22;
    step();
    check("arb_first", {ack0, ack1}, 2'b10);
    req0 = 1'b0;
    step();
    check("arb_second", {ack0, ack1}, 2'b01);
    req1 = 1'b0;
    wait_idle(100, ic);
    check("arb_nstrobe", ev_q.size() - b, 4);
    if (ev_q.size() - b >= 4) begin
      check("arb_order", {ev_q[b].addr, ev_q[b].din, ev_q[b+1].addr, ev_q[b+1].din,
                          ev_q[b+2].addr, ev_q[b+2].din, ev_q[b+3].addr, ev_q[b+3].din},
            {2'd0, 8'h40, 2'd1, 8'h11, 2'd2, 8'h50, 2'd3, 8'h22});
    end

    // FIFO full with the sequencer frozen, then 20 writes through the wrap
    cen_div = 0;
    step(); step();
    b = ev_q.size();
    max_level = 0;
    for (int i = 0; i < 8; i++) send(1, i[0], 8'h10 + 8'(i), 8'h80 + 8'(i), 20, lat, aa);
    check("full_level", level, 8);
    req1 = 1'b1; bank1 = 1'b0; reg1 = 8'h18; val1 = 8'h88;
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ack1) nack++;
    end
    check("full_refused", nack, 0);
    check("full_level_hold", level, 8);
    cen_div = 1;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ack1) begin lat = k; break; end
    end
    check("full_ack_after_pop", (lat > 0), 1);
    req1 = 1'b0;
    step();
    for (int i = 9; i < 20; i++) send(1, i[0], 8'h10 + 8'(i), 8'h80 + 8'(i), 100, lat, aa);
    wait_idle(1000, ic);
    check("full_max_level", max_level, 8);
    check("full_nstrobe", ev_q.size() - b, 40);
    if (ev_q.size() - b >= 40) begin
      for (int i = 0; i < 20; i++) begin
        check($sformatf("wrap%0d", i),
              {ev_q[b+2*i].addr, ev_q[b+2*i].din, ev_q[b+2*i+1].addr, ev_q[b+2*i+1].din},
              {i[0], 1'b0, 8'h10 + 8'(i), i[0], 1'b1, 8'h80 + 8'(i)});
      end
    end

    // Busy stuck high: timeout, next entry still goes out, then clear
    busy = 1'b1;
    b = ev_q.size();
    send(0, 1'b0, 8'h22, 8'h0F, 20, lat, aa);
    send(0, 1'b1, 8'h2B, 8'h80, 20, lat, aa);
    tcyc = -1;
    for (int k = 0; k < 400; k++) begin
      step();
      if (tmo_err) begin tcyc = cyc; break; end
    end
    check("tmo_seen", (tcyc >= 0), 1);
    if (ev_q.size() - b >= 1) check("tmo_cycle", tcyc - ev_q[b].start, 259);
    busy = 1'b0;
    wait_idle(100, ic);
    check("tmo_nstrobe", ev_q.size() - b, 4);
    if (ev_q.size() - b >= 4) begin
      check("tmo_next_entry", {ev_q[b+2].addr, ev_q[b+2].din, ev_q[b+3].addr, ev_q[b+3].din},
            {2'd2, 8'h2B, 2'd3, 8'h80});
    end
    check("tmo_sticky", tmo_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("tmo_cleared", tmo_err, 0);

    // cen every 6th clk: intervals scale by 6, ack latency does not
    cen_div = 6;
    step();
    b = ev_q.size();
    send(0, 1'b1, 8'hA0, 8'h5A, 20, lat, aa);
    wait_idle(200, ic);
    check("cen6_ack_lat", lat, 1);
    check("cen6_nstrobe", ev_q.size() - b, 2);
    if (ev_q.size() - b >= 2) begin
      check("cen6_width_a", ev_q[b].width, 6);
      check("cen6_width_d", ev_q[b+1].width, 6);
      check("cen6_gap", ev_q[b+1].start - ev_q[b].start, 18);
      check("cen6_idle_at", ic - ev_q[b].start, 36);
      check("cen6_data", {ev_q[b].addr, ev_q[b].din, ev_q[b+1].addr, ev_q[b+1].din},
            {2'd2, 8'hA0, 2'd3, 8'h5A});
    end

    // Reset during the address-to-data gap with 3 entries left queued
    cen_div = 0;
    step(); step();
    for (int i = 0; i < 4; i++) send(0, 1'b0, 8'h60 + 8'(i), 8'h70 + 8'(i), 20, lat, aa);
    cen_div = 1;
    nack = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!chip_cs_n) begin nack = 1; break; end
    end
    check("rstmid_addr_strobe", nack, 1);
    step();
    check("rstmid_level_before", level, 3);
    rst = 1'b1;
    step();
    check("rstmid_strobes", {chip_cs_n, chip_wr_n}, 2'b11);
    check("rstmid_level", level, 0);
    check("rstmid_idle", idle, 1);
    rst = 1'b0;
    b = ev_q.size();
    repeat (40) step();
    check("rstmid_no_strobe", ev_q.size() - b, 0);
    check("rstmid_idle_after", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
